// File: rtl/snoop_pkg.sv
// Shared types and field helpers for the snooped CORDIC frame statistics block.
package snoop_pkg;

  localparam int MAG_W     = 16;
  localparam int ANGLE_W   = 16;
  localparam int MAG_LSB   = 0;
  localparam int ANGLE_LSB = 16;

  // Index is carried at a fixed 16-bit width and zero-extended from the frame counter.
  typedef struct packed {
    logic [MAG_W-1:0]   peak_mag;
    logic [ANGLE_W-1:0] peak_angle;
    logic [15:0]        peak_index;
    logic [MAG_W-1:0]   mean_mag;
  } frame_result_t;

  function automatic logic [MAG_W-1:0] get_mag(input logic [31:0] word);
    return word[MAG_LSB +: MAG_W];
  endfunction

  function automatic logic [ANGLE_W-1:0] get_angle(input logic [31:0] word);
    return word[ANGLE_LSB +: ANGLE_W];
  endfunction

endpackage

// File: rtl/frame_result_skid.sv
// Single-entry result holding register with valid/ready, overwrite-on-full
// and a saturating count of results lost to overwrite.
module frame_result_skid
  import snoop_pkg::*;
#(
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  frame_result_t             load_data,
  input  logic                      ready,
  output logic                      valid,
  output frame_result_t             data,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  logic                      valid_r;
  frame_result_t             data_r;
  logic [DROP_CNT_WIDTH-1:0] drop_r;
  logic                      drop_inc_s;

  // A drop is an overwrite of a still-pending result that is not being taken this edge.
  always_comb begin
    drop_inc_s = 1'b0;
    if (load && valid_r && !ready && (drop_r != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_inc_s = 1'b1;
    end else begin
      drop_inc_s = 1'b0;
    end
  end

  // Result register, valid flag and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {$bits(frame_result_t){1'b0}};
      drop_r  <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      if (load) begin
        data_r  <= load_data;
        valid_r <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
      if (drop_inc_s) begin
        drop_r <= drop_r + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign valid      = valid_r;
  assign data       = data_r;
  assign drop_count = drop_r;

endmodule

// File: rtl/snoop_frame_stats.sv
// Per-frame peak/angle/index/mean statistics over snooped CORDIC words;
// the source cannot be stalled, so results are overwritten when unconsumed.
module snoop_frame_stats
  import snoop_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LOG2_FRAME_LEN = 10,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [DATA_WIDTH-1:0]     snooped_data,
  input  logic                      snooped_valid,
  output logic [15:0]               peak_mag_out,
  output logic [15:0]               peak_angle_out,
  output logic [LOG2_FRAME_LEN-1:0] peak_index_out,
  output logic [15:0]               mean_mag_out,
  output logic                      result_valid_out,
  input  logic                      result_ready_in,
  output logic [DROP_CNT_WIDTH-1:0] drop_count_out
);

  localparam int ACC_W = MAG_W + LOG2_FRAME_LEN;

  logic [LOG2_FRAME_LEN-1:0] idx_r;
  logic [ACC_W-1:0]          acc_r;
  logic [MAG_W-1:0]          peak_mag_r;
  logic [ANGLE_W-1:0]        peak_angle_r;
  logic [LOG2_FRAME_LEN-1:0] peak_idx_r;

  logic [MAG_W-1:0]          mag_s;
  logic [ANGLE_W-1:0]        angle_s;
  logic                      first_s;
  logic                      complete_s;
  logic [ACC_W-1:0]          acc_nx_s;
  logic [MAG_W-1:0]          peak_mag_nx_s;
  logic [ANGLE_W-1:0]        peak_angle_nx_s;
  logic [LOG2_FRAME_LEN-1:0] peak_idx_nx_s;
  frame_result_t             result_s;
  frame_result_t             held_s;

  assign mag_s   = get_mag(32'(snooped_data));
  assign angle_s = get_angle(32'(snooped_data));

  // Running-state next values including the current sample; index 0 restarts the frame.
  always_comb begin
    first_s    = (idx_r == {LOG2_FRAME_LEN{1'b0}});
    complete_s = snooped_valid && (idx_r == {LOG2_FRAME_LEN{1'b1}});
    if (first_s || (mag_s > peak_mag_r)) begin
      peak_mag_nx_s   = mag_s;
      peak_angle_nx_s = angle_s;
      peak_idx_nx_s   = idx_r;
    end else begin
      peak_mag_nx_s   = peak_mag_r;
      peak_angle_nx_s = peak_angle_r;
      peak_idx_nx_s   = peak_idx_r;
    end
    if (first_s) begin
      acc_nx_s = ACC_W'(mag_s);
    end else begin
      acc_nx_s = acc_r + ACC_W'(mag_s);
    end
    result_s.peak_mag   = peak_mag_nx_s;
    result_s.peak_angle = peak_angle_nx_s;
    result_s.peak_index = 16'(peak_idx_nx_s);
    result_s.mean_mag   = MAG_W'(acc_nx_s >> LOG2_FRAME_LEN);
  end

  // Running frame state; the index wraps naturally at the power-of-two frame length.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_r        <= {LOG2_FRAME_LEN{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      peak_mag_r   <= {MAG_W{1'b0}};
      peak_angle_r <= {ANGLE_W{1'b0}};
      peak_idx_r   <= {LOG2_FRAME_LEN{1'b0}};
    end else if (snooped_valid) begin
      idx_r        <= idx_r + LOG2_FRAME_LEN'(1);
      acc_r        <= acc_nx_s;
      peak_mag_r   <= peak_mag_nx_s;
      peak_angle_r <= peak_angle_nx_s;
      peak_idx_r   <= peak_idx_nx_s;
    end
  end

  frame_result_skid #(
    .DROP_CNT_WIDTH(DROP_CNT_WIDTH)
  ) u_skid (
    .clk        (clk_in),
    .rst        (rst_in),
    .load       (complete_s),
    .load_data  (result_s),
    .ready      (result_ready_in),
    .valid      (result_valid_out),
    .data       (held_s),
    .drop_count (drop_count_out)
  );

  assign peak_mag_out   = held_s.peak_mag;
  assign peak_angle_out = held_s.peak_angle;
  assign peak_index_out = LOG2_FRAME_LEN'(held_s.peak_index);
  assign mean_mag_out   = held_s.mean_mag;

endmodule

// File: tb/tb_snoop_frame_stats.sv
// Directed self-checking bench for snoop_frame_stats with 4-sample frames.
module tb_snoop_frame_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sdata = 32'd0;
  logic        svalid = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] peak_mag, peak_angle, mean_mag;
  logic [1:0]  peak_index;
  logic        rvalid;
  logic [7:0]  drops;

  int checks = 0;
  int errors = 0;

  snoop_frame_stats #(
    .DATA_WIDTH(32), .LOG2_FRAME_LEN(2), .DROP_CNT_WIDTH(8)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .snooped_data(sdata), .snooped_valid(svalid),
    .peak_mag_out(peak_mag), .peak_angle_out(peak_angle),
    .peak_index_out(peak_index), .mean_mag_out(mean_mag),
    .result_valid_out(rvalid), .result_ready_in(ready),
    .drop_count_out(drops)
  );

  always #5 clk = ~clk;

  // Drive one frame; element 0 of each packed vector is the first sample.
  // Returns at the negedge right after the last sample's capture edge.
  task automatic send_frame(input logic [3:0][15:0] m, input logic [3:0][15:0] a,
                            input logic [3:0][2:0] gaps, input logic ready_last,
                            input logic exp_valid_before);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(gaps[i]); g++) begin
        svalid = 1'b0;
        @(negedge clk);
      end
      if (i == 3) begin
        checks++;
        if (rvalid !== exp_valid_before) begin
          errors++;
          $display("FAIL early_valid got %0b exp %0b", rvalid, exp_valid_before);
        end
        if (ready_last) ready = 1'b1;
      end
      sdata  = {a[i], m[i]};
      svalid = 1'b1;
      @(negedge clk);
    end
    svalid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [15:0] pm, input logic [15:0] pa,
                               input logic [1:0] pi, input logic [15:0] mm, input logic [7:0] dc);
    checks++;
    if (rvalid !== 1'b1 || peak_mag !== pm || peak_angle !== pa || peak_index !== pi ||
        mean_mag !== mm || drops !== dc) begin
      errors++;
      $display("FAIL %s got v=%0b pk=%0h ang=%0h idx=%0d mean=%0h drop=%0d exp v=1 pk=%0h ang=%0h idx=%0d mean=%0h drop=%0d",
               name, rvalid, peak_mag, peak_angle, peak_index, mean_mag, drops, pm, pa, pi, mm, dc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || peak_mag !== 16'd0 || peak_angle !== 16'd0 || peak_index !== 2'd0 ||
        mean_mag !== 16'd0 || drops !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got v=%0b pk=%0h ang=%0h idx=%0d mean=%0h drop=%0d exp all 0",
               rvalid, peak_mag, peak_angle, peak_index, mean_mag, drops);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    ready = 1'b1;
    send_frame({16'd9, 16'd3, 16'd9, 16'd5}, {16'd4, 16'd3, 16'd2, 16'd1}, 12'd0, 1'b0, 1'b0);
    expect_result("basic", 16'd9, 16'd2, 2'd1, 16'd6, 8'd0);
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_fall got %0b exp 0", rvalid);
    end
  endtask

  task automatic test_gaps();
    ready = 1'b1;
    send_frame({16'd9, 16'd3, 16'd9, 16'd5}, {16'd4, 16'd3, 16'd2, 16'd1},
               {3'd2, 3'd5, 3'd0, 3'd3}, 1'b0, 1'b0);
    expect_result("gaps", 16'd9, 16'd2, 2'd1, 16'd6, 8'd0);
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_valid_fall got %0b exp 0", rvalid);
    end
  endtask

  task automatic test_no_overflow();
    ready = 1'b1;
    send_frame({4{16'hFFFF}}, {16'd8, 16'd7, 16'd6, 16'd5}, 12'd0, 1'b0, 1'b0);
    expect_result("all_ones", 16'hFFFF, 16'd5, 2'd0, 16'hFFFF, 8'd0);
    @(negedge clk);
  endtask

  task automatic test_drops();
    ready = 1'b0;
    send_frame({16'd4, 16'd4, 16'd4, 16'd10}, {16'd14, 16'd13, 16'd12, 16'd11}, 12'd0, 1'b0, 1'b0);
    expect_result("drop_f1", 16'd10, 16'd11, 2'd0, 16'd5, 8'd0);
    send_frame({16'd3, 16'd2, 16'd20, 16'd1}, {16'd24, 16'd23, 16'd22, 16'd21}, 12'd0, 1'b0, 1'b1);
    expect_result("drop_f2", 16'd20, 16'd22, 2'd1, 16'd6, 8'd1);
    send_frame({16'd6, 16'd30, 16'd0, 16'd0}, {16'd34, 16'd33, 16'd32, 16'd31}, 12'd0, 1'b0, 1'b1);
    expect_result("drop_f3", 16'd30, 16'd33, 2'd2, 16'd9, 8'd2);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || drops !== 8'd2) begin
      errors++;
      $display("FAIL drop_transfer got v=%0b drop=%0d exp v=0 drop=2", rvalid, drops);
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    send_frame({16'd0, 16'd0, 16'd0, 16'd40}, {16'd44, 16'd43, 16'd42, 16'd41}, 12'd0, 1'b0, 1'b0);
    expect_result("b2b_a", 16'd40, 16'd41, 2'd0, 16'd10, 8'd2);
    send_frame({16'd44, 16'd3, 16'd2, 16'd1}, {16'd54, 16'd53, 16'd52, 16'd51}, 12'd0, 1'b1, 1'b1);
    ready = 1'b0;
    expect_result("b2b_same_edge", 16'd44, 16'd54, 2'd3, 16'd12, 8'd2);
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold got %0b exp 1", rvalid);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %0b exp 0", rvalid);
    end
  endtask

  task automatic test_reset_mid_frame();
    ready = 1'b0;
    send_frame({4{16'd5}}, {4{16'd9}}, 12'd0, 1'b0, 1'b0);
    expect_result("pre_reset", 16'd5, 16'd9, 2'd0, 16'd5, 8'd2);
    for (int i = 0; i < 2; i++) begin
      sdata  = {16'd60, 16'd100};
      svalid = 1'b1;
      @(negedge clk);
    end
    svalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || drops !== 8'd0 || peak_mag !== 16'd0 || mean_mag !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%0b drop=%0d pk=%0h mean=%0h exp all 0", rvalid, drops, peak_mag, mean_mag);
    end
    send_frame({16'd8, 16'd3, 16'd50, 16'd7}, {16'd4, 16'd3, 16'd2, 16'd1}, 12'd0, 1'b1, 1'b0);
    ready = 1'b0;
    expect_result("post_reset", 16'd50, 16'd2, 2'd1, 16'd17, 8'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_no_overflow();
    test_drops();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
